mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-port, synchronous-read instruction/data memory between the fetch requester and the data-memory requester, so both pipeline stages can share one physical RAM. Data accesses have priority; a run-length guard bounds fetch starvation. The block translates byte addresses to word indices, rejects out-of-range accesses with a fault flag, and routes each one-cycle-latency read response back to the requester that issued it.

## Interface

- `ADDR_WIDTH`, 14, byte-address width of the memory window; holds 2^(ADDR_WIDTH-2) words.
- `ADDR_OFFSET`, 'h3000, byte address mapped to word 0.
- `MAX_DATA_RUN`, 4, consecutive data grants allowed while a fetch waits; range 1..15.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `if_req` in 1: fetch read request.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out 32: fetch read data.
- `if_fault` out 1: with `if_rvalid`, the access was out of range.
- `dm_req` in 1: data request.
- `dm_we` in 1: data write.
- `dm_be` in 4: write byte enables.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: write data.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1: data read response valid; reads only.
- `dm_rdata` out 32: data read data.
- `dm_fault` out 1: with `dm_rvalid`, or in the cycle after a granted write, the access was out of range.
- `mem_en` out 1, `mem_we` out 1, `mem_be` out 4, `mem_idx` out ADDR_WIDTH-2, `mem_wdata` out 32: memory command.
- `mem_rdata` in 32: memory read data, valid one cycle after a read command.

## Operation

- **Per-cycle grant.** At most one grant per cycle.
  - `dm_gnt = dm_req && !(if_req && run == MAX_DATA_RUN)`.
  - `if_gnt = if_req && !dm_gnt`.
  - Both grants are forced to 0 while `reset` is high.
- **Starvation counter `run`.** 4-bit register.
  - `dm_gnt && if_req`: increment, saturating at MAX_DATA_RUN.
  - `if_gnt`, or `if_req` low: clear to 0.
  - Otherwise: hold.
- **Address decode.** `off = addr - ADDR_OFFSET`.
  - In range iff `off[31:ADDR_WIDTH] == 0`.
  - `mem_idx = off[ADDR_WIDTH-1:2]`.
  - Low two address bits are ignored.
- **Memory command.**
  - `mem_en = granted && in_range`.
  - `mem_we = dm_gnt && dm_we`.
  - `mem_be` and `mem_wdata` come from the data port on writes; they are 0 otherwise.
  - An out-of-range write is dropped, with no `mem_en`.
- **Response tracking.** Register `owner` with values NONE, IF, DM, plus register `fault_q`, loaded every cycle.
  - owner = IF on `if_gnt`.
  - owner = DM on a `dm_gnt` read.
  - owner = NONE otherwise.
- **Response outputs.**
  - `if_rvalid = (owner == IF)`; `dm_rvalid` likewise for DM.
  - `*_rdata` = `mem_rdata` when the port owns the response and `!fault_q`; 0 otherwise.
  - `*_fault` = `fault_q` for the owning port.
  - A faulting write raises `dm_fault` for one cycle without `dm_rvalid`.
- **Reset, including mid-operation.**
  - owner = NONE, `run` = 0, `fault_q` = 0.
  - Any pending response is discarded, so all rvalid/fault/rdata outputs read 0.

## Timing

- Grant is combinational from the requests in the same cycle.
- Read response arrives exactly 1 cycle after the grant.
- Full throughput: one access per cycle, back-to-back grants allowed.
- Write completes at the grant edge.
- Reset values: all outputs are 0.
- Simultaneous requests: data wins unless `run == MAX_DATA_RUN`, in which case fetch wins.
- A fetch waits at most MAX_DATA_RUN cycles.

## Structure

- Shared definitions file holds:
  - owner encoding constants OWN_NONE=0, OWN_IF=1, OWN_DM=2;
  - the default ADDR_OFFSET.
- One sub-module, `mem_addr_check`, instantiated twice:
  - parameters ADDR_WIDTH and ADDR_OFFSET;
  - input: byte address;
  - outputs: `in_range` and `idx`.
- Arbitration, counter and response registers live in the top module.

## Test plan

- **Fetch only.** `if_req` with addrs 'h3000, 'h3004 in consecutive cycles; memory preloaded → `if_gnt` both cycles; `if_rvalid` and `if_rdata` = mem[0], mem[1] one cycle after each grant.
- **Contention.** `if_req` and `dm_req` read held high continuously with MAX_DATA_RUN=4 → grant pattern DM,DM,DM,DM,IF repeating.
- **Write then read.** `dm_req` write 'hDEADBEEF, be='b0011, at 'h3010, followed by a read of 'h3010 → `mem_we` with `mem_idx`=4; read returns the RAM model's merged value; no `dm_rvalid` on the write.
- **Out of range.** Fetch at 'h2FFC and at 'h3000+(1<<14) → `if_gnt`=1, `mem_en`=0; next cycle `if_rvalid`=1, `if_fault`=1, `if_rdata`=0.
- **Reset mid-read.** Assert `reset` asynchronously in the cycle after a `dm_gnt` read → `dm_rvalid`/`dm_rdata` drop to 0 immediately; after release, `run`=0 and the first simultaneous request goes to data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// response-owner encoding, default memory window base, counter width.
package mem_port_arbiter_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    localparam logic [31:0] DEF_ADDR_OFFSET = 32'h0000_3000;

    localparam int RUN_W = 4;

endpackage

// File: rtl/mem_addr_check.sv
// Byte address to word index translation with window range check.
// Ports: addr (byte address in), in_range (inside window), idx (word index).
module mem_addr_check
    import mem_port_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 14,
    parameter logic [31:0] ADDR_OFFSET = DEF_ADDR_OFFSET
) (
    input  logic [31:0]           addr,
    output logic                  in_range,
    output logic [ADDR_WIDTH-3:0] idx
);

    logic [31:0] off;
    logic        unused_lo;

    assign off      = addr - ADDR_OFFSET;
    assign in_range = (off[31:ADDR_WIDTH] == '0);
    assign idx      = off[ADDR_WIDTH-1:2];

    // Sub-word byte offset has no meaning for a word-wide RAM.
    assign unused_lo = ^off[1:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync-read RAM between fetch and data requesters.
// Data has priority; a run counter bounds fetch starvation.
// Ports: clk/reset; if_* fetch port; dm_* data port; mem_* RAM command
// and mem_rdata (valid one cycle after a read command).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 14,
    parameter logic [31:0] ADDR_OFFSET  = DEF_ADDR_OFFSET,
    parameter int          MAX_DATA_RUN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    output logic                  if_fault,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [3:0]            dm_be,
    input  logic [31:0]           dm_addr,
    input  logic [31:0]           dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [31:0]           dm_rdata,
    output logic                  dm_fault,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-3:0] mem_idx,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_DATA_RUN);

    logic                  if_in_range;
    logic                  dm_in_range;
    logic [ADDR_WIDTH-3:0] if_idx;
    logic [ADDR_WIDTH-3:0] dm_idx;

    logic [RUN_W-1:0] run_q, run_d;
    logic [1:0]       owner_q, owner_d;
    logic             fault_q, fault_d;

    logic dm_rd_gnt;
    logic dm_wr_gnt;

    mem_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_OFFSET(ADDR_OFFSET)
    ) u_if_chk (
        .addr    (if_addr),
        .in_range(if_in_range),
        .idx     (if_idx)
    );

    mem_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_OFFSET(ADDR_OFFSET)
    ) u_dm_chk (
        .addr    (dm_addr),
        .in_range(dm_in_range),
        .idx     (dm_idx)
    );

    // Fetch takes the slot once the data run has reached its limit.
    assign dm_gnt = !reset && dm_req
                  && !(if_req && run_q == MAX_RUN);
    assign if_gnt = !reset && if_req && !dm_gnt;

    assign dm_rd_gnt = dm_gnt && !dm_we;
    assign dm_wr_gnt = dm_gnt && dm_we;

    assign mem_en    = (if_gnt && if_in_range)
                     || (dm_gnt && dm_in_range);
    assign mem_we    = dm_wr_gnt;
    assign mem_be    = dm_wr_gnt ? dm_be : 4'b0000;
    assign mem_wdata = dm_wr_gnt ? dm_wdata : 32'h0;
    assign mem_idx   = dm_gnt ? dm_idx
                     : (if_gnt ? if_idx : '0);

    always_comb begin
        run_d = run_q;
        unique case (1'b1)
            dm_gnt && if_req: begin
                if (run_q != MAX_RUN) run_d = run_q + 1'b1;
            end
            if_gnt || !if_req: run_d = '0;
            default: ;
        endcase
    end

    // A faulting write leaves owner NONE but still loads fault_q,
    // which is how dm_fault is raised without dm_rvalid.
    always_comb begin
        owner_d = OWN_NONE;
        fault_d = 1'b0;
        unique case (1'b1)
            if_gnt: begin
                owner_d = OWN_IF;
                fault_d = !if_in_range;
            end
            dm_rd_gnt: begin
                owner_d = OWN_DM;
                fault_d = !dm_in_range;
            end
            dm_wr_gnt: fault_d = !dm_in_range;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= '0;
            owner_q <= OWN_NONE;
            fault_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            owner_q <= owner_d;
            fault_q <= fault_d;
        end
    end

    assign if_rvalid = (owner_q == OWN_IF);
    assign dm_rvalid = (owner_q == OWN_DM);

    assign if_fault  = if_rvalid && fault_q;
    assign dm_fault  = fault_q
                     && (owner_q == OWN_DM || owner_q == OWN_NONE);

    assign if_rdata  = (if_rvalid && !fault_q) ? mem_rdata : 32'h0;
    assign dm_rdata  = (dm_rvalid && !fault_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a sync-read RAM model.
// Ports: drives all DUT inputs, checks grants, commands and responses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid, if_fault;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = 4'h0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        dm_gnt, dm_rvalid, dm_fault;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_idx;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit          dm;
        bit          rv;
        bit          flt;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    logic [31:0] ram [4096];

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_fault (if_fault),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .dm_fault (dm_fault),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_idx  (mem_idx),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: word i holds 0x1000_0000 + i after reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++)
                ram[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b])
                        ram[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_idx];
            end
        end
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input bit dm, input bit rv,
                        input bit flt, input logic [31:0] d);
        exp_t e;
        e.dm = dm;
        e.rv = rv;
        e.flt = flt;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dw,
                         input logic [3:0] db,
                         input logic [31:0] da,
                         input logic [31:0] dd);
        @(negedge clk);
        if_req = ir;
        if_addr = ia;
        dm_req = dr;
        dm_we = dw;
        dm_be = db;
        dm_addr = da;
        dm_wdata = dd;
        #1;
    endtask

    // Monitor: every response cycle pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("if_rvalid", if_rvalid, !e.dm && e.rv);
                check("if_fault", if_fault, !e.dm && e.flt);
                check("if_rdata", if_rdata, e.dm ? 32'h0 : e.data);
                check("dm_rvalid", dm_rvalid, e.dm && e.rv);
                check("dm_fault", dm_fault, e.dm && e.flt);
                check("dm_rdata", dm_rdata, e.dm ? e.data : 32'h0);
            end else if (if_rvalid || dm_rvalid
                         || if_fault || dm_fault) begin
                check("unexpected_rsp", 1, 0);
            end
        end
    end

    initial begin
        bit exp_if;
        if_req = 1'b1;
        dm_req = 1'b1;
        #2;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_dm_gnt", dm_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_dm_rvalid", dm_rvalid, 0);
        check("rst_dm_fault", dm_fault, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if_req = 1'b0;
        dm_req = 1'b0;
        reset = 1'b0;

        // Fetch only.
        drive(1, 32'h3000, 0, 0, 4'h0, 32'h0, 32'h0);
        check("f0_if_gnt", if_gnt, 1);
        check("f0_mem_en", mem_en, 1);
        check("f0_mem_idx", mem_idx, 0);
        push(0, 1, 0, 32'h1000_0000);
        drive(1, 32'h3004, 0, 0, 4'h0, 32'h0, 32'h0);
        check("f1_if_gnt", if_gnt, 1);
        check("f1_mem_idx", mem_idx, 1);
        push(0, 1, 0, 32'h1000_0001);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Contention: DM,DM,DM,DM,IF repeating.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h3008, 1, 0, 4'h0, 32'h3020, 32'h0);
            exp_if = (i % 5 == 4);
            check("cont_if_gnt", if_gnt, exp_if);
            check("cont_dm_gnt", dm_gnt, !exp_if);
            if (exp_if) push(0, 1, 0, 32'h1000_0002);
            else push(1, 1, 0, 32'h1000_0008);
        end
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Write then read back.
        drive(0, 32'h0, 1, 1, 4'b0011, 32'h3010, 32'hDEAD_BEEF);
        check("wr_dm_gnt", dm_gnt, 1);
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_idx", mem_idx, 4);
        check("wr_mem_be", mem_be, 4'b0011);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        drive(0, 32'h0, 1, 0, 4'h0, 32'h3010, 32'h0);
        check("rd_dm_gnt", dm_gnt, 1);
        check("rd_mem_we", mem_we, 0);
        check("rd_mem_be", mem_be, 0);
        push(1, 1, 0, 32'h1000_BEEF);

        // Out-of-range write: dropped, one-cycle dm_fault.
        drive(0, 32'h0, 1, 1, 4'hF, 32'h2000, 32'h1234_5678);
        check("owr_dm_gnt", dm_gnt, 1);
        check("owr_mem_en", mem_en, 0);
        push(1, 0, 1, 32'h0);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Out-of-range fetches, below and above the window.
        drive(1, 32'h2FFC, 0, 0, 4'h0, 32'h0, 32'h0);
        check("olo_if_gnt", if_gnt, 1);
        check("olo_mem_en", mem_en, 0);
        push(0, 1, 1, 32'h0);
        drive(1, 32'h7000, 0, 0, 4'h0, 32'h0, 32'h0);
        check("ohi_if_gnt", if_gnt, 1);
        check("ohi_mem_en", mem_en, 0);
        push(0, 1, 1, 32'h0);
        drive(1, 32'h6FFC, 0, 0, 4'h0, 32'h0, 32'h0);
        check("top_mem_en", mem_en, 1);
        check("top_mem_idx", mem_idx, 12'hFFF);
        push(0, 1, 0, 32'h1000_0FFF);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Reset mid-read with the run counter at its limit.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h3008, 1, 0, 4'h0, 32'h3020, 32'h0);
            check("pre_dm_gnt", dm_gnt, 1);
            push(1, 1, 0, 32'h1000_0008);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_dm_rvalid", dm_rvalid, 0);
        check("mid_dm_rdata", dm_rdata, 0);
        check("mid_dm_fault", dm_fault, 0);
        check("mid_dm_gnt", dm_gnt, 0);
        check("mid_if_gnt", if_gnt, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_dm_gnt", dm_gnt, 1);
        check("post_if_gnt", if_gnt, 0);
        push(1, 1, 0, 32'h1000_0008);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
